// File: rtl/timer_arb_pkg.sv
// Shared types and helpers for the timer arbiter and its down-counter core.
package timer_arb_pkg;

    localparam int DEF_N = 4;
    localparam int DEF_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COUNT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    // Sized for the largest supported requester count; callers slice to N.
    function automatic logic [7:0] onehot(input logic [2:0] idx);
        return 8'b1 << idx;
    endfunction

endpackage

// File: rtl/timer_arbiter_down_count_core.sv
// W-bit loadable down-counter that saturates at zero.
module down_count_core #(
    parameter int W = 4
) (
    input  logic         CLK,
    input  logic         MR,
    input  logic         LOAD,
    input  logic [W-1:0] LD_VAL,
    input  logic         EN,
    output logic [W-1:0] Q,
    output logic         ZERO
);

    always_ff @(posedge CLK) begin
        if (!MR)
            Q <= '0;
        else if (LOAD)
            Q <= LD_VAL;
        else if (EN && (Q != '0))
            Q <= Q - 1'b1;
    end

    assign ZERO = (Q == '0);

endmodule

// File: rtl/timer_arbiter.sv
// Shares one down-counter among N requesters; round-robin by default,
// lowest-index fixed priority when TIMER_ARB_FIXED_PRI_EN is defined.
module timer_arbiter
    import timer_arb_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int W = DEF_W
) (
    input  logic           CLK,
    input  logic           MR,
    input  logic           EN,
    input  logic [N-1:0]   REQ,
    input  logic [N*W-1:0] DUR,
    output logic [N-1:0]   GNT,
    output logic [N-1:0]   DONE,
    output logic           BUSY,
    output logic [W-1:0]   Q,
    output logic           CO
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    state_t         state, state_nxt;
    logic [N-1:0]   gnt_nxt, done_nxt;
    logic           busy_nxt, co_nxt;
    logic [IW-1:0]  win;
    logic           win_vld;
    logic           ld, cnt_en, zero, abort;
    logic [W-1:0]   ld_val;
    logic [7:0]     win_oh;

`ifndef TIMER_ARB_FIXED_PRI_EN
    // Index where the next round-robin search begins.
    logic [IW-1:0]  ptr, ptr_nxt;
`endif

    // Descending scan: the last hit is the first candidate in search order.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
`ifdef TIMER_ARB_FIXED_PRI_EN
        for (int k = N - 1; k >= 0; k--) begin
            if (REQ[k]) begin
                win     = IW'(k);
                win_vld = 1'b1;
            end
        end
`else
        for (int k = N - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(ptr) + k) % N;
            if (REQ[idx]) begin
                win     = IW'(idx);
                win_vld = 1'b1;
            end
        end
`endif
    end

    assign win_oh = onehot(3'(win));
    assign abort  = ((GNT & REQ) == '0);

    always_comb begin
        state_nxt = state;
        gnt_nxt   = GNT;
        busy_nxt  = BUSY;
        done_nxt  = '0;
        co_nxt    = 1'b0;
        ld        = 1'b0;
        ld_val    = DUR[int'(win)*W +: W];
        cnt_en    = 1'b0;
`ifndef TIMER_ARB_FIXED_PRI_EN
        ptr_nxt   = ptr;
`endif
        case (state)
            ST_IDLE: begin
                gnt_nxt  = '0;
                busy_nxt = 1'b0;
                if (win_vld) begin
                    gnt_nxt   = win_oh[N-1:0];
                    busy_nxt  = 1'b1;
                    ld        = 1'b1;
                    state_nxt = ST_COUNT;
`ifndef TIMER_ARB_FIXED_PRI_EN
                    ptr_nxt   = IW'((int'(win) + 1) % N);
`endif
                end
            end
            ST_COUNT: begin
                // A dropped request wins over a simultaneous expiry.
                if (abort) begin
                    gnt_nxt   = '0;
                    busy_nxt  = 1'b0;
                    ld        = 1'b1;
                    ld_val    = '0;
                    state_nxt = ST_IDLE;
                end else if (EN && zero) begin
                    done_nxt  = GNT;
                    co_nxt    = 1'b1;
                    state_nxt = ST_RELEASE;
                end else begin
                    cnt_en = EN;
                end
            end
            ST_RELEASE: begin
                gnt_nxt   = '0;
                busy_nxt  = 1'b0;
                state_nxt = ST_IDLE;
            end
            default: begin
                gnt_nxt   = '0;
                busy_nxt  = 1'b0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!MR) begin
            state <= ST_IDLE;
            GNT   <= '0;
            DONE  <= '0;
            BUSY  <= 1'b0;
            CO    <= 1'b0;
`ifndef TIMER_ARB_FIXED_PRI_EN
            ptr   <= '0;
`endif
        end else begin
            state <= state_nxt;
            GNT   <= gnt_nxt;
            DONE  <= done_nxt;
            BUSY  <= busy_nxt;
            CO    <= co_nxt;
`ifndef TIMER_ARB_FIXED_PRI_EN
            ptr   <= ptr_nxt;
`endif
        end
    end

    down_count_core #(.W(W)) u_core (
        .CLK    (CLK),
        .MR     (MR),
        .LOAD   (ld),
        .LD_VAL (ld_val),
        .EN     (cnt_en),
        .Q      (Q),
        .ZERO   (zero)
    );

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed bench for timer_arbiter (N=4, W=4) with hand-computed expectations.
module tb_timer_arbiter;

    localparam int N = 4;
    localparam int W = 4;

    logic           CLK = 1'b0;
    logic           MR  = 1'b0;
    logic           EN  = 1'b1;
    logic [N-1:0]   REQ = '0;
    logic [N*W-1:0] DUR = '0;
    logic [N-1:0]   GNT, DONE;
    logic           BUSY, CO;
    logic [W-1:0]   Q;

    int nchk = 0;
    int nerr = 0;

    timer_arbiter #(.N(N), .W(W)) dut (
        .CLK  (CLK),
        .MR   (MR),
        .EN   (EN),
        .REQ  (REQ),
        .DUR  (DUR),
        .GNT  (GNT),
        .DONE (DONE),
        .BUSY (BUSY),
        .Q    (Q),
        .CO   (CO)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        MR = 1'b0;
        tick();
        MR = 1'b1;
    endtask

    initial begin
        int exp_idx, cyc;
        logic seen0, wrapped, done_seen;

        // Reset state
        REQ = 4'b0000;
        tick();
        tick();
        chk("rst_gnt", 32'(GNT), 0);
        chk("rst_busy", 32'(BUSY), 0);
        chk("rst_q", 32'(Q), 0);
        chk("rst_done", 32'(DONE), 0);
        chk("rst_co", 32'(CO), 0);
        MR = 1'b1;

        // Single request, DUR0=3
        DUR = {4'd0, 4'd0, 4'd0, 4'd3};
        REQ = 4'b0001;
        tick();
        chk("sgl_gnt", 32'(GNT), 32'b0001);
        chk("sgl_busy", 32'(BUSY), 1);
        chk("sgl_q3", 32'(Q), 3);
        tick(); chk("sgl_q2", 32'(Q), 2);
        tick(); chk("sgl_q1", 32'(Q), 1);
        tick(); chk("sgl_q0", 32'(Q), 0);
        chk("sgl_nodone", 32'(DONE), 0);
        tick();
        chk("sgl_done", 32'(DONE), 32'b0001);
        chk("sgl_co", 32'(CO), 1);
        chk("sgl_q0b", 32'(Q), 0);
        REQ = 4'b0000;
        tick();
        chk("sgl_rel_done", 32'(DONE), 0);
        chk("sgl_rel_co", 32'(CO), 0);
        chk("sgl_rel_gnt", 32'(GNT), 0);
        chk("sgl_rel_busy", 32'(BUSY), 0);
        tick();
        chk("sgl_idle_gnt", 32'(GNT), 0);

        // Arbitration order with all requesters pending, DUR=0
        do_reset();
        DUR = '0;
        REQ = 4'b1111;
        for (int g = 0; g < 5; g++) begin
`ifdef TIMER_ARB_FIXED_PRI_EN
            exp_idx = 0;
`else
            exp_idx = g % N;
`endif
            tick();
            chk($sformatf("rr_gnt%0d", g), 32'(GNT), 32'(1) << exp_idx);
            tick();
            chk($sformatf("rr_done%0d", g), 32'(DONE), 32'(1) << exp_idx);
            tick();
            chk($sformatf("rr_gap%0d", g), 32'(GNT), 0);
        end
        REQ = 4'b0000;
        tick();

        // Pause: DUR1=2, EN low three cycles after the first decrement
        do_reset();
        DUR = {4'd0, 4'd0, 4'd2, 4'd0};
        REQ = 4'b0010;
        tick(); chk("pz_gnt", 32'(GNT), 32'b0010);
        chk("pz_q2", 32'(Q), 2);
        tick(); chk("pz_q1", 32'(Q), 1);
        EN = 1'b0;
        for (int p = 0; p < 3; p++) begin
            tick();
            chk($sformatf("pz_hold%0d", p), 32'(Q), 1);
            chk($sformatf("pz_nodone%0d", p), 32'(DONE), 0);
        end
        EN = 1'b1;
        tick(); chk("pz_q0", 32'(Q), 0);
        chk("pz_nodone_q0", 32'(DONE), 0);
        tick(); chk("pz_done", 32'(DONE), 32'b0010);
        chk("pz_co", 32'(CO), 1);
        REQ = 4'b0000;
        tick();
        tick();

        // Abort: REQ2 dropped at Q=4 while REQ3 pends
        do_reset();
        DUR = {4'd1, 4'd6, 4'd0, 4'd0};
        REQ = 4'b1100;
        tick(); chk("ab_gnt2", 32'(GNT), 32'b0100);
        chk("ab_q6", 32'(Q), 6);
        tick();
        tick(); chk("ab_q4", 32'(Q), 4);
        REQ = 4'b1000;
        tick();
        chk("ab_gnt0", 32'(GNT), 0);
        chk("ab_busy0", 32'(BUSY), 0);
        chk("ab_q0", 32'(Q), 0);
        chk("ab_nodone", 32'(DONE), 0);
        chk("ab_noco", 32'(CO), 0);
        tick();
        chk("ab_gnt3", 32'(GNT), 32'b1000);
        chk("ab_q1", 32'(Q), 1);
        tick(); tick();
        chk("ab_done3", 32'(DONE), 32'b1000);
        REQ = 4'b0000;
        tick(); tick();

        // Abort beats simultaneous expiry (DUR=0, request dropped at once)
        do_reset();
        DUR = '0;
        REQ = 4'b0001;
        tick(); chk("abx_gnt", 32'(GNT), 32'b0001);
        REQ = 4'b0000;
        tick();
        chk("abx_nodone", 32'(DONE), 0);
        chk("abx_noco", 32'(CO), 0);
        chk("abx_gnt0", 32'(GNT), 0);

        // Boundary: DUR=15 needs 16 enabled COUNT edges
        do_reset();
        DUR = {4'd0, 4'd0, 4'd0, 4'd15};
        REQ = 4'b0001;
        tick(); chk("max_q15", 32'(Q), 15);
        cyc = 0; seen0 = 1'b0; wrapped = 1'b0; done_seen = 1'b0;
        while (cyc < 40 && !done_seen) begin
            tick();
            cyc++;
            if (seen0 && Q == 4'd15) wrapped = 1'b1;
            if (Q == 4'd0) seen0 = 1'b1;
            if (DONE != '0) done_seen = 1'b1;
        end
        chk("max_seen", 32'(done_seen), 1);
        chk("max_cycles", 32'(cyc), 16);
        chk("max_nowrap", 32'(wrapped), 0);
        REQ = 4'b0000;
        tick(); tick();

        // Reset mid-count at Q=5
        DUR = {4'd0, 4'd0, 4'd0, 4'd9};
        REQ = 4'b0001;
        tick(); chk("mr_q9", 32'(Q), 9);
        for (int s = 0; s < 4; s++) tick();
        chk("mr_q5", 32'(Q), 5);
        MR = 1'b0;
        REQ = 4'b0000;
        tick();
        chk("mr_gnt", 32'(GNT), 0);
        chk("mr_busy", 32'(BUSY), 0);
        chk("mr_q", 32'(Q), 0);
        chk("mr_done", 32'(DONE), 0);
        MR = 1'b1;
        tick();
        chk("mr_idle_gnt", 32'(GNT), 0);
        chk("mr_idle_done", 32'(DONE), 0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/timer_arbiter.md
Name: timer_arbiter

Overview:
- Shares one W-bit loadable down-counter between N requesters that each need a timed interval.
- Arbitrates pending requests, loads the winner's duration, counts down to zero, then pulses DONE back to that requester.
- Sits between the down-counter datapath and the client FSMs that need delays; replaces per-client counters.

Parameters:
- N, 4, number of requesters (2..8)
- W, 4, counter and duration width in bits

Ports:
- CLK  in  1  rising-edge clock
- MR  in  1  reset; synchronous, active-low
- EN  in  1  global count enable; 0 pauses the count, arbitration unaffected
- REQ  in  N  level request per requester; hold until DONE
- DUR  in  N*W  per-requester duration; slice i = DUR[i*W +: W]; sampled only at grant
- GNT  out  N  one-hot grant, registered
- DONE  out  N  one-cycle pulse to the granted requester at expiry
- BUSY  out  1  1 while a grant is held
- Q  out  W  current counter value
- CO  out  1  one-cycle pulse at expiry, same cycle as DONE

Behaviour:
- Reset: when MR=0 at a CLK edge, all of the following are forced: state=IDLE, GNT=0, DONE=0, BUSY=0, Q=0, CO=0, round-robin pointer=0. Reset mid-count drops the grant silently with no DONE.
- States: IDLE, COUNT, RELEASE.
- IDLE:
  - If REQ != 0, select a winner i (arbitration below).
  - Next edge: GNT=onehot(i), BUSY=1, Q=DUR slice i, go to COUNT.
  - If REQ=0, stay in IDLE with all outputs 0.
- Arbitration (default round-robin):
  - Search starts at index (last_winner+1) mod N and wraps.
  - Pointer updates only when a grant is issued.
- COUNT:
  - EN=1 and Q!=0: Q<=Q-1.
  - EN=0: Q holds.
  - EN=1 and Q==0: DONE[i]=1 and CO=1 for exactly one cycle; Q stays 0; go to RELEASE.
  - Interval = DUR+1 enabled cycles in COUNT; DUR=0 gives DONE after one enabled cycle.
  - Q never wraps below 0.
- Abort: REQ[i] falls while in COUNT. Next edge: GNT=0, BUSY=0, Q=0, no DONE/CO, go to IDLE. Abort takes priority over simultaneous expiry.
- RELEASE:
  - GNT=0, BUSY=0, DONE=0, CO=0; go to IDLE.
  - This guarantees at least one idle cycle between grants.
  - A requester still asserting REQ is re-arbitrated and loses to any other pending requester under round-robin.
- Changes to DUR or to other REQ bits during COUNT have no effect.
- GNT is always one-hot or zero. DONE is always a subset of the GNT held in the previous cycle.

Optional Feature:
- Macro: TIMER_ARB_FIXED_PRI_EN.
- Defined: fixed priority; the lowest asserted REQ index always wins; round-robin pointer removed.
- Undefined: round-robin as above.
- All other timing is identical in both builds.

Decomposition:
- Shared package timer_arb_pkg holds:
  - state encoding constants ST_IDLE, ST_COUNT, ST_RELEASE (2-bit)
  - default N/W constants
  - a onehot helper function
- One natural sub-module, down_count_core: W-bit counter with inputs CLK, MR, LOAD, LD_VAL, EN; outputs Q and ZERO.
  - Saturates at 0 and has synchronous active-low reset.
  - The arbiter FSM drives LOAD and EN.

Test Plan:
- Reset: drive MR=0 mid-COUNT with Q=5 -> next edge GNT=0, BUSY=0, Q=0, no DONE; IDLE afterwards.
- Single request: REQ=0001, DUR0=3, EN=1 -> GNT=0001 one edge later; Q sequence 3,2,1,0; DONE=0001 and CO=1 for one cycle on the 4th COUNT edge; then RELEASE, IDLE.
- Round-robin: REQ=1111 held (re-raised after each DONE), all DUR=0 -> grant order 0,1,2,3,0; never the same index twice in a row while others pend.
  - Fixed-priority build: the same stimulus grants index 0 every time.
- Pause: DUR1=2, EN low for 3 cycles after the first decrement -> Q holds at 1; DONE is delayed exactly 3 cycles versus EN=1.
- Abort: REQ2 dropped while Q=4 -> no DONE/CO; GNT clears next edge; a pending REQ3 is granted on the following arbitration.
- Boundary: DUR=15 (max) -> 16 enabled COUNT cycles to DONE; DUR=0 -> DONE on the first COUNT edge; Q never shows 15 after 0.
